tx_packetizer: RTL and testbench
================================

Name: tx_packetizer

Overview:
- Sits directly downstream of the Tx data generator and upstream of the PSK modulator/pulse shaper.
- Consumes the generator's AXIS payload stream (tuser = is_bpsk) together with its payload_length.
- Frames each packet as preamble, then 16-bit length header, then payload, then idle gap, and emits a registered 2-bit symbol stream with a per-symbol BPSK/QPSK flag.
- Pulses pkt_sent when a packet, including its gap, is complete. The generator uses this to restart its next packet.

Parameters:
- BYTES, 1, input tdata width in bytes (AXIS, at least 1).
- PREAMBLE_LEN, 32, preamble length in BPSK symbols (1..32).
- PREAMBLE, 32'hF3A0_5C6D, preamble pattern. Bits [PREAMBLE_LEN-1:0] are sent MSB-first.
- GAP_LEN, 16, idle cycles after payload (at least 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_tdata  in  BYTES*8  payload word. Only bits [1:0] are used.
- in_tvalid  in  1  payload valid.
- in_tready  out  1  payload ready.
- in_tlast  in  1  last payload word (optional marker).
- in_tuser  in  1  1 = symbol is BPSK, 0 = QPSK.
- payload_length  in  16  payload symbols per packet. Sampled at packet start.
- out_sym  out  2  symbol bits {I,Q}.
- out_valid  out  1  symbol valid.
- out_ready  in  1  modulator ready.
- out_is_bpsk  out  1  symbol is BPSK.
- out_sof  out  1  high with the first preamble symbol.
- pkt_sent  out  1  one-cycle pulse: packet done.
- len_err  out  1  sticky length-mismatch flag. Cleared only by rst.

Behaviour:
- Reset (async, rst=1): state IDLE. out_sym=0, out_valid=0, out_is_bpsk=0, out_sof=0, pkt_sent=0, len_err=0, in_tready=0, all counters 0.
- All outputs are registered.
- Output handshake:
  - A symbol transfers when out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out_sym, out_is_bpsk and out_sof hold stable.
  - The next symbol is loaded on the transfer edge, giving zero bubbles when out_ready is stuck at 1.
- BPSK mapping: bit b gives out_sym={b,b}, out_is_bpsk=1.
- QPSK mapping: out_sym=in_tdata[1:0], out_is_bpsk=0.
- IDLE:
  - in_tready=0, out_valid=0.
  - When in_tvalid=1: latch len_q<=payload_length and go to PREAMBLE.
  - The next cycle presents preamble bit PREAMBLE_LEN-1 with out_valid=1 and out_sof=1.
- PREAMBLE:
  - Sends PREAMBLE_LEN BPSK symbols, MSB-first.
  - After the last transfer, go to HEADER.
- HEADER:
  - Sends 16 BPSK symbols, len_q[15] first, then to PAYLOAD.
  - If len_q==0, go to GAP instead.
- PAYLOAD:
  - in_tready = out_ready || !out_valid.
  - Each input handshake loads one output symbol, mapped per in_tuser. in_tdata[0] is used for BPSK.
  - The payload counter increments per input handshake (16-bit, no wrap within a packet).
  - Normal end: the counter reaches len_q, go to GAP. in_tlast on that word is optional and not checked.
  - Early tlast: in_tlast accepted with count<len_q. Set len_err=1 and go to GAP.
  - While in PAYLOAD with in_tvalid=0: out_valid drops after the pending symbol transfers. No timeout.
- GAP:
  - in_tready=0.
  - out_valid falls once the final payload symbol has transferred.
  - Counts GAP_LEN cycles starting after that transfer, independent of out_ready.
  - On completion: pkt_sent=1 for exactly one cycle and state returns to IDLE on the same edge.
- Back-to-back packets: IDLE may restart on the cycle after pkt_sent if in_tvalid=1. payload_length is re-sampled at that point.
- Mid-operation reset: immediate return to reset values. No pkt_sent is generated. Partial packets are abandoned.
- payload_length changes mid-packet have no effect until the next IDLE sample.

Test Plan:
- Reset then idle: rst pulse with in_tvalid=0 -> all outputs 0 and in_tready=0 for 100 cycles.
- BPSK packet:
  - Stimulus: payload_length=4, in_tuser=1, in_tdata bit0 pattern 1,0,1,1, out_ready=1.
  - Required: out_sof on the first symbol, {1,1}. Then 32 preamble symbols matching F3A05C6D MSB-first.
  - Header: 13×{0,0}, {1,1}, {0,0}, {0,0}.
  - Payload: {1,1},{0,0},{1,1},{1,1}.
  - pkt_sent once, 16 cycles of out_valid=0 after the last payload transfer. len_err=0.
- QPSK mapping: payload_length=3, in_tuser=0, in_tdata[1:0]=2'b01,2'b10,2'b11 -> payload out_sym 01,10,11 with out_is_bpsk=0. Header symbols have out_is_bpsk=1.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 repeatedly across a full packet.
  - Required: out_sym is stable whenever out_valid && !out_ready.
  - Symbol sequence is identical to the out_ready=1 run. No input word is dropped or duplicated.
- Early tlast: payload_length=8, in_tlast on word 5 -> exactly 5 payload symbols, len_err=1 and stays 1, pkt_sent still pulses after GAP.
- Reset mid-payload: assert rst after 2 of 4 payload symbols -> outputs 0 immediately, no pkt_sent. The next packet after release starts with out_sof and the full preamble.

Source files
------------

// File: rtl/tx_packetizer.sv
// Frames a payload symbol stream as preamble, 16-bit length header, payload and
// idle gap, and emits a registered 2-bit symbol stream with a BPSK/QPSK flag.
module tx_packetizer #(
    parameter int unsigned BYTES        = 1,
    parameter int unsigned PREAMBLE_LEN = 32,
    parameter logic [31:0] PREAMBLE     = 32'hF3A0_5C6D,
    parameter int unsigned GAP_LEN      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTES*8-1:0] in_tdata,
    input  logic               in_tvalid,
    output logic               in_tready,
    input  logic               in_tlast,
    input  logic               in_tuser,
    input  logic [15:0]        payload_length,
    output logic [1:0]         out_sym,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_is_bpsk,
    output logic               out_sof,
    output logic               pkt_sent,
    output logic               len_err
);

    typedef enum logic [2:0] {StIdle, StPreamble, StHeader, StPayload, StGap} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  sym_q, sym_d;
    logic        valid_q, valid_d;
    logic        bpsk_q, bpsk_d;
    logic        sof_q, sof_d;
    logic        pkt_sent_q, pkt_sent_d;
    logic        len_err_q, len_err_d;
    logic [31:0] pre_idx;
    logic [31:0] hdr_idx;
    logic        xfer;
    logic        in_hs;
    logic        unused_tdata;

    // Only the two low payload bits carry symbol data.
    assign unused_tdata = ^in_tdata;

    assign xfer  = valid_q && out_ready;
    assign in_hs = in_tvalid && in_tready;

    // Input ready: open in payload, and during the last header symbol's transfer so the
    // first payload symbol follows without a bubble.
    always_comb begin
        in_tready = 1'b0;
        case (state_q)
            StPayload: in_tready = out_ready || !valid_q;
            StHeader:  in_tready = out_ready && (cnt_q == 32'd16) && (len_q != 16'd0);
            default:   in_tready = 1'b0;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pay_cnt_d  = pay_cnt_q;
        len_d      = len_q;
        sym_d      = sym_q;
        valid_d    = valid_q;
        bpsk_d     = bpsk_q;
        sof_d      = sof_q;
        pkt_sent_d = 1'b0;
        len_err_d  = len_err_q;
        pre_idx    = PREAMBLE_LEN - 32'd1 - cnt_q;
        hdr_idx    = 32'd15 - cnt_q;

        case (state_q)
            StIdle: begin
                if (in_tvalid) begin
                    // cnt_q is zero here, so pre_idx selects the top preamble bit.
                    len_d     = payload_length;
                    state_d   = StPreamble;
                    sym_d     = {2{PREAMBLE[pre_idx[4:0]]}};
                    valid_d   = 1'b1;
                    bpsk_d    = 1'b1;
                    sof_d     = 1'b1;
                    cnt_d     = 32'd1;
                    pay_cnt_d = 16'd0;
                end
            end
            StPreamble: begin
                if (xfer) begin
                    sof_d = 1'b0;
                    if (cnt_q < PREAMBLE_LEN) begin
                        sym_d = {2{PREAMBLE[pre_idx[4:0]]}};
                        cnt_d = cnt_q + 32'd1;
                    end else begin
                        state_d = StHeader;
                        sym_d   = {2{len_q[15]}};
                        cnt_d   = 32'd1;
                    end
                end
            end
            StHeader: begin
                if (xfer) begin
                    if (cnt_q < 32'd16) begin
                        sym_d = {2{len_q[hdr_idx[3:0]]}};
                        cnt_d = cnt_q + 32'd1;
                    end else begin
                        valid_d = 1'b0;
                        cnt_d   = 32'd0;
                        state_d = (len_q == 16'd0) ? StGap : StPayload;
                    end
                end
            end
            StPayload: begin
                if (xfer) valid_d = 1'b0;
            end
            StGap: begin
                // Gap counting starts only once the final symbol has left.
                if (valid_q) begin
                    if (out_ready) valid_d = 1'b0;
                end else if (cnt_q == GAP_LEN - 32'd1) begin
                    pkt_sent_d = 1'b1;
                    state_d    = StIdle;
                    cnt_d      = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (in_hs) begin
            sym_d     = in_tuser ? {2{in_tdata[0]}} : in_tdata[1:0];
            bpsk_d    = in_tuser;
            valid_d   = 1'b1;
            sof_d     = 1'b0;
            pay_cnt_d = pay_cnt_q + 16'd1;
            cnt_d     = 32'd0;
            if (pay_cnt_d == len_q) begin
                state_d = StGap;
            end else if (in_tlast) begin
                len_err_d = 1'b1;
                state_d   = StGap;
            end else begin
                state_d = StPayload;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 32'd0;
            pay_cnt_q  <= 16'd0;
            len_q      <= 16'd0;
            sym_q      <= 2'b00;
            valid_q    <= 1'b0;
            bpsk_q     <= 1'b0;
            sof_q      <= 1'b0;
            pkt_sent_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pay_cnt_q  <= pay_cnt_d;
            len_q      <= len_d;
            sym_q      <= sym_d;
            valid_q    <= valid_d;
            bpsk_q     <= bpsk_d;
            sof_q      <= sof_d;
            pkt_sent_q <= pkt_sent_d;
            len_err_q  <= len_err_d;
        end
    end

    assign out_sym     = sym_q;
    assign out_valid   = valid_q;
    assign out_is_bpsk = bpsk_q;
    assign out_sof     = sof_q;
    assign pkt_sent    = pkt_sent_q;
    assign len_err     = len_err_q;

endmodule

// File: tb/tb_tx_packetizer.sv
// Self-checking bench for tx_packetizer: directed and randomized packets checked
// against a symbol-list model built from the framing rules.
module tb_tx_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_tdata;
    logic        in_tvalid;
    logic        in_tready;
    logic        in_tlast;
    logic        in_tuser;
    logic [15:0] payload_length;
    logic [1:0]  out_sym;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_bpsk;
    logic        out_sof;
    logic        pkt_sent;
    logic        len_err;

    int checks = 0;
    int errors = 0;

    logic [1:0] w_data[$];
    bit         w_user[$];
    bit         exp_len_err;

    always #5 clk = ~clk;

    tx_packetizer dut (
        .clk            (clk),
        .rst            (rst),
        .in_tdata       (in_tdata),
        .in_tvalid      (in_tvalid),
        .in_tready      (in_tready),
        .in_tlast       (in_tlast),
        .in_tuser       (in_tuser),
        .payload_length (payload_length),
        .out_sym        (out_sym),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_is_bpsk    (out_is_bpsk),
        .out_sof        (out_sof),
        .pkt_sent       (pkt_sent),
        .len_err        (len_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({out_sym, out_valid, out_is_bpsk, out_sof, pkt_sent, len_err, in_tready});
    endfunction

    // mode: 0 = QPSK words, 1 = BPSK words, 2 = random mix.
    task automatic fill(input int n, input int mode);
        w_data = {};
        w_user = {};
        for (int i = 0; i < n; i++) begin
            w_data.push_back(2'($urandom_range(0, 3)));
            w_user.push_back(mode == 2 ? bit'($urandom_range(0, 1)) : bit'(mode));
        end
    endtask

    // rmode: 0 = out_ready stuck high, 1 = pattern 1,0,0,1, 2 = random.
    task automatic run_pkt(input string name, input int len, input int tlast_pos,
                           input int rmode, input int abort_after);
        logic [2:0]  exp_q[$];
        logic [31:0] pre;
        logic [15:0] lenv;
        logic [3:0]  held_val;
        int nwords, widx, cyc, nx, last_x, pkt_cyc, pkts;
        int unstable, seq_err, sof_err, valid_after;
        bit started, wv, held, aborted;

        pre = 32'hF3A0_5C6D;
        lenv = 16'(len);
        nwords = (tlast_pos > 0 && tlast_pos < len) ? tlast_pos : len;
        exp_q = {};
        for (int i = 31; i >= 0; i--) exp_q.push_back({1'b1, {2{pre[i]}}});
        for (int i = 15; i >= 0; i--) exp_q.push_back({1'b1, {2{lenv[i]}}});
        for (int k = 0; k < nwords; k++)
            exp_q.push_back(w_user[k] ? {1'b1, {2{w_data[k][0]}}} : {1'b0, w_data[k]});
        if (tlast_pos > 0 && tlast_pos < len && abort_after == 0) exp_len_err = 1'b1;

        widx = 0; cyc = 0; nx = 0; last_x = -1; pkt_cyc = -1; pkts = 0;
        unstable = 0; seq_err = 0; sof_err = 0; valid_after = 0;
        started = 1'b0; wv = 1'b0; held = 1'b0; held_val = 4'h0; aborted = 1'b0;

        while (cyc < 3000) begin
            @(negedge clk);
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            payload_length = started ? 16'($urandom) : lenv;
            if (!started) wv = 1'b1;
            else if (widx < nwords) begin
                if (!wv) wv = ($urandom_range(0, 3) != 0);
            end else wv = 1'b0;
            in_tvalid = wv;
            in_tdata  = (widx < nwords) ? {6'b0, w_data[widx]} : 8'h00;
            in_tuser  = (widx < nwords) ? w_user[widx] : 1'b0;
            in_tlast  = (widx + 1 == tlast_pos) || (tlast_pos == 0 && widx + 1 == len);
            #1;
            if (out_valid) started = 1'b1;
            if (held && ({out_sof, out_is_bpsk, out_sym} !== held_val || !out_valid))
                unstable++;
            if (nx == exp_q.size() && out_valid) valid_after++;
            if (out_valid && out_ready) begin
                if (nx < exp_q.size() && {out_is_bpsk, out_sym} !== exp_q[nx]) seq_err++;
                if (out_sof !== (nx == 0)) sof_err++;
                nx++;
                last_x = cyc;
            end
            held = out_valid && !out_ready;
            held_val = {out_sof, out_is_bpsk, out_sym};
            if (in_tvalid && in_tready) begin
                widx++;
                wv = 1'b0;
            end
            if (pkt_sent) begin
                pkts++;
                if (pkt_cyc < 0) pkt_cyc = cyc;
            end
            if (abort_after > 0 && nx == 48 + abort_after) begin
                aborted = 1'b1;
                break;
            end
            if (pkt_cyc >= 0 && cyc == pkt_cyc + 1) break;
            cyc++;
        end

        if (abort_after > 0) begin
            check({name, "_reached_abort"}, 32'(aborted), 32'd1);
            @(posedge clk);
            #2 rst = 1'b1;
            #1 check({name, "_async_rst_outs"}, all_outs(), 32'd0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (pkt_sent) pkts++;
            end
            check({name, "_no_pkt_sent"}, 32'(pkts), 32'd0);
            check({name, "_rst_outs"}, all_outs(), 32'd0);
            in_tvalid = 1'b0;
            rst = 1'b0;
            exp_len_err = 1'b0;
        end else begin
            check({name, "_timeout"}, 32'(pkt_cyc >= 0), 32'd1);
            check({name, "_sym_count"}, 32'(nx), 32'(exp_q.size()));
            check({name, "_sym_errors"}, 32'(seq_err), 32'd0);
            check({name, "_sof_errors"}, 32'(sof_err), 32'd0);
            check({name, "_hold_unstable"}, 32'(unstable), 32'd0);
            check({name, "_valid_in_gap"}, 32'(valid_after), 32'd0);
            check({name, "_words_taken"}, 32'(widx), 32'(nwords));
            check({name, "_pkt_sent_pulses"}, 32'(pkts), 32'd1);
            check({name, "_gap_cycles"}, 32'(pkt_cyc - last_x), 32'd17);
            check({name, "_len_err"}, 32'(len_err), 32'(exp_len_err));
        end
    endtask

    initial begin
        int len, tl;
        rst = 1'b1;
        in_tdata = 8'h00;
        in_tvalid = 1'b0;
        in_tlast = 1'b0;
        in_tuser = 1'b0;
        payload_length = 16'd0;
        out_ready = 1'b1;
        exp_len_err = 1'b0;

        // Reset, then idle with no input for 100 cycles.
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            #1 check("idle_outs", all_outs(), 32'd0);
        end

        // BPSK packet, payload bits 1,0,1,1.
        fill(4, 1);
        w_data = '{2'b01, 2'b00, 2'b11, 2'b01};
        run_pkt("bpsk", 4, 0, 0, 0);

        // QPSK mapping.
        fill(3, 0);
        w_data = '{2'b01, 2'b10, 2'b11};
        run_pkt("qpsk", 3, 0, 0, 0);

        // Same BPSK packet under 1,0,0,1 backpressure.
        fill(4, 1);
        w_data = '{2'b01, 2'b00, 2'b11, 2'b01};
        run_pkt("backpressure", 4, 0, 1, 0);

        // Early tlast on word 5 of 8; len_err must stick across the next packet.
        fill(8, 2);
        run_pkt("early_tlast", 8, 5, 0, 0);
        fill(2, 2);
        run_pkt("after_err", 2, 0, 2, 0);

        // Empty payload goes straight from header to gap.
        fill(0, 0);
        run_pkt("zero_len", 0, 0, 1, 0);

        // Reset after 2 of 4 payload symbols, then a full clean packet.
        fill(4, 1);
        run_pkt("mid_reset", 4, 0, 0, 2);
        fill(5, 2);
        run_pkt("post_reset", 5, 0, 0, 0);

        // Randomized back-to-back packets.
        for (int p = 0; p < 10; p++) begin
            len = $urandom_range(0, 10);
            tl = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
            fill(len, 2);
            run_pkt($sformatf("rand%0d", p), len, tl, $urandom_range(0, 2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
